// File: rtl/ethernet_pkg.sv
// rtl/ethernet_pkg.sv - shared states, wire constants and CRC helpers for the ethernet receive front end
package ethernet_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_START_OF_FRAME,
        S_MAC_DESTINATION,
        S_PAYLOAD,
        S_DROP_PACKET,
        S_FINISH
    } state_type;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
    localparam int          MAC_BYTES     = 6;
    localparam int          FCS_BYTES     = 4;

    // The wire is LSB-first, so the CRC register runs bit-reversed relative to the polynomial.
    function automatic logic [31:0] reflect32(input logic [31:0] value);
        logic [31:0] result;
        for (int i = 0; i < 32; i++) result[i] = value[31 - i];
        return result;
    endfunction

endpackage

// File: rtl/ethernet_crc32.sv
// rtl/ethernet_crc32.sv - byte-wide reflected CRC-32 with registered state and combinational next value
module ethernet_crc32
    import ethernet_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    localparam logic [31:0] POLY_REFLECTED = reflect32(CRC32_POLY);

    logic [31:0] crc;

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++)
            crc_next = (crc_next[0] ^ data[i]) ? ((crc_next >> 1) ^ POLY_REFLECTED) : (crc_next >> 1);
    end

    always_ff @(posedge clock) begin
        if (reset || clear) crc <= '1;
        else if (enable)    crc <= crc_next;
    end

endmodule

// File: rtl/ethernet_frame_receiver.sv
// rtl/ethernet_frame_receiver.sv - preamble/SFD detect, per-slot MAC match, FCS-stripping forwarder
// Define ETHERNET_FCS_CHECK_EN to make packet_good also require a correct CRC-32.
module ethernet_frame_receiver
    import ethernet_pkg::*;
#(
    parameter int RECEIVE_QUE_SLOTS  = 1,
    parameter int PREAMBLE_BYTES     = 7,
    parameter int MIN_FRAME_BYTES    = 64,
    parameter int MAX_FRAME_BYTES    = 1518,
    parameter int DROP_COUNTER_WIDTH = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [7:0]                      data,
    input  logic                            data_enable,
    input  logic                            data_last,
    input  logic [RECEIVE_QUE_SLOTS-1:0]    recieve_slot_enable,
    input  logic [48*RECEIVE_QUE_SLOTS-1:0] slot_mac_address,
    output logic [7:0]                      packet_data,
    output logic [RECEIVE_QUE_SLOTS-1:0]    packet_data_valid,
    output logic                            packet_start,
    output logic                            packet_end,
    output logic                            packet_good,
    output logic [DROP_COUNTER_WIDTH-1:0]   dropped_frame_count
);

    localparam int          PRE_W      = (PREAMBLE_BYTES > 1) ? $clog2(PREAMBLE_BYTES) : 1;
    localparam logic [10:0] MIN_LEN    = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] MAX_PLUS   = 11'(MAX_FRAME_BYTES + 1);
    localparam logic [10:0] MAC_LEN    = 11'(MAC_BYTES);
    localparam logic [2:0]  FLUSH_LAST = 3'(MAC_BYTES - FCS_BYTES);

    state_type                    state;
    logic [PRE_W-1:0]             preamble_count;
    logic [10:0]                  frame_count;
    logic [10:0]                  frame_next;
    logic [39:0]                  dest_shift;
    logic [47:0]                  dest_address;
    logic [7:0]                   delay_line [MAC_BYTES];
    logic [RECEIVE_QUE_SLOTS-1:0] slot_mask;
    logic [RECEIVE_QUE_SLOTS-1:0] match_mask;
    logic                         forwarding;
    logic                         frame_good;
    logic [2:0]                   flush_count;
    logic                         accept;
    logic                         fcs_ok;
    logic                         end_good;

    assign accept       = data_enable && (state == S_MAC_DESTINATION || state == S_PAYLOAD);
    assign frame_next   = frame_count + 11'd1;
    assign dest_address = {dest_shift, data};
    assign end_good     = (frame_next >= MIN_LEN) && fcs_ok;

    always_comb begin
        match_mask = '0;
        for (int i = 0; i < RECEIVE_QUE_SLOTS; i++)
            match_mask[i] = recieve_slot_enable[i] &&
                            (dest_address == slot_mac_address[48*i +: 48] || dest_address == BROADCAST_MAC);
    end

`ifdef ETHERNET_FCS_CHECK_EN
    logic [31:0] crc_next;

    ethernet_crc32 fcs_crc (
        .clock    (clock),
        .reset    (reset),
        .clear    (state == S_START_OF_FRAME),
        .enable   (accept),
        .data     (data),
        .crc_next (crc_next)
    );

    assign fcs_ok = (reflect32(crc_next) == CRC32_RESIDUE);
`else
    assign fcs_ok = 1'b1;
`endif

    function automatic logic [DROP_COUNTER_WIDTH-1:0] saturate_increment(input logic [DROP_COUNTER_WIDTH-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

    // Delay line keeps the newest MAC_BYTES frame bytes; index 0 is the oldest.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
            dest_shift  <= '0;
            for (int i = 0; i < MAC_BYTES; i++) delay_line[i] <= '0;
        end else begin
            if (state == S_START_OF_FRAME) frame_count <= '0;
            else if (accept)               frame_count <= frame_next;
            if (accept) begin
                for (int i = 0; i < MAC_BYTES - 1; i++) delay_line[i] <= delay_line[i+1];
                delay_line[MAC_BYTES-1] <= data;
            end
            if (accept && state == S_MAC_DESTINATION) dest_shift <= {dest_shift[31:0], data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= S_IDLE;
            preamble_count      <= '0;
            slot_mask           <= '0;
            forwarding          <= 1'b0;
            frame_good          <= 1'b0;
            flush_count         <= '0;
            packet_data         <= '0;
            packet_data_valid   <= '0;
            packet_start        <= 1'b0;
            packet_end          <= 1'b0;
            packet_good         <= 1'b0;
            dropped_frame_count <= '0;
        end else begin
            packet_data       <= '0;
            packet_data_valid <= '0;
            packet_start      <= 1'b0;
            packet_end        <= 1'b0;
            packet_good       <= 1'b0;
            case (state)
                S_IDLE: if (data_enable && data == PREAMBLE_BYTE) begin
                    if (data_last || recieve_slot_enable == '0) begin
                        dropped_frame_count <= saturate_increment(dropped_frame_count);
                        state <= data_last ? S_IDLE : S_DROP_PACKET;
                    end else begin
                        preamble_count <= PRE_W'(PREAMBLE_BYTES - 1);
                        state <= (PREAMBLE_BYTES == 1) ? S_START_OF_FRAME : S_PREAMBLE;
                    end
                end
                S_PREAMBLE: if (data_enable) begin
                    if (data_last || data != PREAMBLE_BYTE) begin
                        dropped_frame_count <= saturate_increment(dropped_frame_count);
                        state <= data_last ? S_IDLE : S_DROP_PACKET;
                    end else begin
                        preamble_count <= preamble_count - 1'b1;
                        if (preamble_count == PRE_W'(1)) state <= S_START_OF_FRAME;
                    end
                end
                S_START_OF_FRAME: if (data_enable) begin
                    if (data_last || data != SFD_BYTE) begin
                        dropped_frame_count <= saturate_increment(dropped_frame_count);
                        state <= data_last ? S_IDLE : S_DROP_PACKET;
                    end else begin
                        forwarding <= 1'b0;
                        state      <= S_MAC_DESTINATION;
                    end
                end
                S_MAC_DESTINATION: if (data_enable && (data_last || frame_next == MAC_LEN)) begin
                    if (frame_next == MAC_LEN && match_mask != '0) begin
                        slot_mask <= match_mask;
                        if (data_last) begin
                            frame_good  <= end_good;
                            flush_count <= '0;
                            state       <= S_FINISH;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end else begin
                        dropped_frame_count <= saturate_increment(dropped_frame_count);
                        state <= data_last ? S_IDLE : S_DROP_PACKET;
                    end
                end
                S_PAYLOAD: if (data_enable) begin
                    if (frame_next == MAX_PLUS) begin
                        // Oversize: abort immediately, close any started packet as bad.
                        dropped_frame_count <= saturate_increment(dropped_frame_count);
                        packet_end <= forwarding;
                        state <= data_last ? S_IDLE : S_DROP_PACKET;
                    end else begin
                        packet_data       <= delay_line[0];
                        packet_data_valid <= slot_mask;
                        packet_start      <= !forwarding;
                        forwarding        <= 1'b1;
                        if (data_last) begin
                            frame_good  <= end_good;
                            flush_count <= '0;
                            state       <= S_FINISH;
                        end
                    end
                end
                S_DROP_PACKET: if (data_enable && data_last) state <= S_IDLE;
                S_FINISH: begin
                    if (flush_count == FLUSH_LAST) begin
                        packet_end  <= 1'b1;
                        packet_good <= frame_good;
                        state       <= S_IDLE;
                    end else begin
                        packet_data       <= delay_line[flush_count];
                        packet_data_valid <= slot_mask;
                        packet_start      <= !forwarding;
                        forwarding        <= 1'b1;
                        flush_count       <= flush_count + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_frame_receiver.sv
// tb/tb_ethernet_frame_receiver.sv - directed frame tests for ethernet_frame_receiver
module tb_ethernet_frame_receiver;

    localparam int SLOTS = 4;
    localparam logic [47:0] MAC0 = 48'h0200_0000_0010;
    localparam logic [47:0] MAC2 = 48'h0200_0000_0012;
    localparam logic [47:0] MAC3 = 48'h0200_0000_0013;

    logic               clock = 1'b0;
    logic               reset;
    logic [7:0]         data;
    logic               data_enable;
    logic               data_last;
    logic [SLOTS-1:0]   recieve_slot_enable;
    logic [48*SLOTS-1:0] slot_mac_address;
    logic [7:0]         packet_data;
    logic [SLOTS-1:0]   packet_data_valid;
    logic               packet_start;
    logic               packet_end;
    logic               packet_good;
    logic [15:0]        dropped_frame_count;

    ethernet_frame_receiver #(.RECEIVE_QUE_SLOTS(SLOTS)) dut (
        .clock               (clock),
        .reset               (reset),
        .data                (data),
        .data_enable         (data_enable),
        .data_last           (data_last),
        .recieve_slot_enable (recieve_slot_enable),
        .slot_mac_address    (slot_mac_address),
        .packet_data         (packet_data),
        .packet_data_valid   (packet_data_valid),
        .packet_start        (packet_start),
        .packet_end          (packet_end),
        .packet_good         (packet_good),
        .dropped_frame_count (dropped_frame_count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] frame[$];
    logic [7:0] rx[$];
    int mask_err, start_cnt, start_err, end_cnt, end_at, sent, exp_drops;
    logic end_good;
    logic [SLOTS-1:0] exp_mask;
    logic exp_flip_good;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clear_capture();
        rx.delete();
        mask_err = 0; start_cnt = 0; start_err = 0; end_cnt = 0; end_at = 0; sent = 0;
        end_good = 1'bx;
    endtask

    task automatic sample();
        if (packet_start && packet_data_valid == '0) start_err++;
        if (packet_data_valid != '0) begin
            if (rx.size() == 0 && !packet_start) start_err++;
            if (rx.size() != 0 && packet_start) start_err++;
            if (packet_data_valid !== exp_mask) mask_err++;
            rx.push_back(packet_data);
        end
        if (packet_start) start_cnt++;
        if (packet_end) begin
            end_cnt++;
            end_good = packet_good;
            end_at = sent;
        end
    endtask

    task automatic step(input logic en, input logic [7:0] d, input logic last);
        data = d; data_enable = en; data_last = last;
        @(posedge clock);
        @(negedge clock);
        sample();
    endtask

    task automatic build_frame(input logic [47:0] dest, input int len, input logic [7:0] seed);
        logic [31:0] c;
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(dest[47-8*i -: 8]);
        for (int i = 6; i < len - 4; i++) frame.push_back(8'(i * 7) ^ seed);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < frame.size(); i++) begin
            c = c ^ {24'd0, frame[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frame.push_back(c[8*i +: 8]);
    endtask

    task automatic send_frame(input int bad_index);
        clear_capture();
        for (int i = 0; i < 7; i++) step(1'b1, (i == bad_index) ? 8'h54 : 8'h55, 1'b0);
        step(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < frame.size(); i++) begin
            if (i % 17 == 16) step(1'b0, 8'h00, 1'b0);
            sent = i + 1;
            step(1'b1, frame[i], i == frame.size() - 1);
        end
        repeat (6) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_rx(input string tag, input int fwd, input int ends, input logic good, input int at);
        int errs;
        errs = 0;
        for (int i = 0; i < rx.size() && i < fwd; i++)
            if (rx[i] !== frame[i]) errs++;
        check_value({tag, "_count"}, rx.size(), fwd);
        check_value({tag, "_bytes"}, errs, 0);
        check_value({tag, "_mask"}, mask_err, 0);
        check_value({tag, "_start"}, start_cnt, (fwd > 0) ? 1 : 0);
        check_value({tag, "_start_align"}, start_err, 0);
        check_value({tag, "_end"}, end_cnt, ends);
        if (ends > 0) begin
            check_value({tag, "_good"}, end_good, good);
            check_value({tag, "_end_at"}, end_at, at);
        end
        check_value({tag, "_drops"}, dropped_frame_count, exp_drops);
    endtask

    initial begin
        reset = 1'b1; data = '0; data_enable = 1'b0; data_last = 1'b0;
        recieve_slot_enable = '0;
        slot_mac_address = {MAC3, MAC2, 48'h0200_0000_0011, MAC0};
        exp_mask = '0; exp_drops = 0;
        clear_capture();
        @(negedge clock);
        @(negedge clock);
        check_value("reset_valid", packet_data_valid, 0);
        check_value("reset_data", packet_data, 0);
        check_value("reset_start_end", {packet_start, packet_end, packet_good}, 0);
        check_value("reset_drops", dropped_frame_count, 0);
        reset = 1'b0;
        repeat (2) step(1'b0, 8'h00, 1'b0);

        // No slot enabled: dropped on the first preamble byte.
        build_frame(MAC0, 64, 8'h00);
        send_frame(-1); exp_drops = 1;
        check_rx("no_slot", 0, 0, 1'b0, 0);

        recieve_slot_enable = 4'b0001; exp_mask = 4'b0001;
        send_frame(-1);
        check_rx("slot0", 60, 1, 1'b1, 64);

        recieve_slot_enable = 4'b1010; exp_mask = 4'b1010;
        build_frame(48'hFFFF_FFFF_FFFF, 64, 8'h11);
        send_frame(-1);
        check_rx("bcast", 60, 1, 1'b1, 64);

        recieve_slot_enable = 4'b1111; exp_mask = 4'b1000;
        build_frame(MAC3, 64, 8'h22);
        send_frame(-1);
        check_rx("slot3", 60, 1, 1'b1, 64);

        recieve_slot_enable = 4'b0001; exp_mask = 4'b0001;
        build_frame(MAC0, 64, 8'h33);
        send_frame(2); exp_drops++;
        check_rx("bad_pre", 0, 0, 1'b0, 0);
        send_frame(-1);
        check_rx("after_bad", 60, 1, 1'b1, 64);

        build_frame(MAC2, 64, 8'h44);
        send_frame(-1); exp_drops++;
        check_rx("no_match", 0, 0, 1'b0, 0);

        build_frame(MAC0, 40, 8'h55);
        send_frame(-1);
        check_rx("runt", 36, 1, 1'b0, 40);

        build_frame(MAC0, 64, 8'h03);
        frame[20] = frame[20] ^ 8'h04;
`ifdef ETHERNET_FCS_CHECK_EN
        exp_flip_good = 1'b0;
`else
        exp_flip_good = 1'b1;
`endif
        send_frame(-1);
        check_rx("bit_flip", 60, 1, exp_flip_good, 64);

        build_frame(MAC0, 1600, 8'h66);
        send_frame(-1); exp_drops++;
        check_rx("oversize", 1512, 1, 1'b0, 1519);

        // Reset in the middle of forwarding.
        build_frame(MAC0, 64, 8'h77);
        clear_capture();
        for (int i = 0; i < 7; i++) step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, frame[i], 1'b0);
        check_value("pre_reset_count", rx.size(), 24);
        reset = 1'b1;
        step(1'b1, frame[30], 1'b0);
        check_value("mid_reset_valid", packet_data_valid, 0);
        check_value("mid_reset_data", packet_data, 0);
        check_value("mid_reset_end", {packet_start, packet_end, packet_good}, 0);
        check_value("mid_reset_drops", dropped_frame_count, 0);
        reset = 1'b0; exp_drops = 0;
        clear_capture();
        for (int i = 0; i < 20; i++) step(1'b1, 8'hA0, 1'b0);
        step(1'b1, 8'hA0, 1'b1);
        repeat (6) step(1'b0, 8'h00, 1'b0);
        check_rx("post_reset", 0, 0, 1'b0, 0);

        send_frame(-1);
        check_rx("recover", 60, 1, 1'b1, 64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ethernet_frame_receiver.md
Name: ethernet_frame_receiver

Overview:
Byte-wide Ethernet receive front end and the successor of the single-stage preamble checker. It detects preamble and SFD, then matches the destination MAC against a per-slot address table. It forwards the frame (destination MAC through payload, FCS stripped) to every matching receive slot and reports frame length and CRC-32 status at end of frame. It sits between the PHY byte interface and the per-slot receive queues.

Parameters:
RECEIVE_QUE_SLOTS, 1, number of receive slots; width of all per-slot ports.
PREAMBLE_BYTES, 7, count of 0x55 bytes required before SFD 0xD5.
MIN_FRAME_BYTES, 64, minimum legal length, destination MAC through FCS inclusive.
MAX_FRAME_BYTES, 1518, maximum legal length on the same basis.
DROP_COUNTER_WIDTH, 16, width of dropped_frame_count.

Ports:
clock  input  1  single clock domain.
reset  input  1  synchronous, active-high.
data  input  8  received byte.
data_enable  input  1  byte strobe; gaps allowed anywhere.
data_last  input  1  qualifies data_enable; marks last byte of the frame (last FCS byte).
recieve_slot_enable  input  RECEIVE_QUE_SLOTS  slot i may accept frames.
slot_mac_address  input  48*RECEIVE_QUE_SLOTS  slot i address at [48i+47:48i]; first wire byte is [47:40].
packet_data  output  8  forwarded byte.
packet_data_valid  output  RECEIVE_QUE_SLOTS  one-hot-or-multi slot mask qualifying packet_data.
packet_start  output  1  pulse with first forwarded byte.
packet_end  output  1  pulse one cycle after last forwarded byte.
packet_good  output  1  valid with packet_end; 1 means length legal and FCS correct.
dropped_frame_count  output  DROP_COUNTER_WIDTH  saturating count of dropped frames.

Behaviour:
- Reset: all outputs 0, state S_IDLE, counters and delay line cleared. Reset mid-frame abandons the frame with no packet_end. Remaining bytes are parsed from S_IDLE.
- States: S_IDLE, S_PREAMBLE, S_START_OF_FRAME, S_MAC_DESTINATION, S_PAYLOAD, S_DROP_PACKET, S_FINISH.
- S_IDLE: ignores bytes other than 0x55. On 0x55 with no slot enabled, goes to S_DROP_PACKET. Otherwise goes to S_PREAMBLE with the preamble counter at PREAMBLE_BYTES-1.
- S_PREAMBLE: each 0x55 decrements the counter; at 0 goes to S_START_OF_FRAME. Any other byte goes to S_DROP_PACKET.
- S_START_OF_FRAME: 0xD5 goes to S_MAC_DESTINATION. Any other byte goes to S_DROP_PACKET.
- S_MAC_DESTINATION: shifts in 6 bytes. On the 6th byte, computes the match mask:
  - bit i set when recieve_slot_enable[i] and (address == slot i address or address == FF:FF:FF:FF:FF:FF).
  - recieve_slot_enable is sampled at that cycle.
  - Empty mask goes to S_DROP_PACKET; otherwise the mask is latched and the state goes to S_PAYLOAD.
- Forwarding: a 6-byte delay line holds all bytes from the destination MAC on. When a byte enters a full line, the oldest byte leaves on packet_data with the latched mask, one cycle after the accepting edge. packet_start accompanies the first such byte (wire byte 1 on the arrival of byte 7).
- End of frame: data_last in S_PAYLOAD goes to S_FINISH. The two oldest delay-line bytes are emitted on the next two consecutive cycles. The final 4 bytes (FCS) are discarded. packet_end and packet_good assert on the following cycle.
- Length: an 11-bit frame byte counter starts at the first destination byte.
  - Length below MIN_FRAME_BYTES at data_last gives packet_good=0.
  - Reaching MAX_FRAME_BYTES+1 goes to S_DROP_PACKET immediately. If forwarding has started, packet_end with packet_good=0 is issued on the next cycle without flushing.
- data_last in S_PREAMBLE, S_START_OF_FRAME or S_MAC_DESTINATION counts as a drop and returns to S_IDLE. No packet_start or packet_end is issued.
- S_DROP_PACKET: outputs idle; waits for data_last, then returns to S_IDLE. Entry increments dropped_frame_count, saturating at all-ones. Oversize frames count once. CRC failures are not drops.
- data_enable with data_last on the same byte as the state-advancing byte: the transition happens, then the data_last rule of the new context applies on that same byte.

Optional Feature:
- Macro ETHERNET_FCS_CHECK_EN.
- Defined: a CRC-32 is run over destination MAC through FCS (IEEE 802.3 reflected polynomial 0x04C11DB7, init all-ones). packet_good additionally requires the residue 0xC704DD7B.
- Undefined: the CRC logic is absent and packet_good reflects the length checks only. The FCS is still stripped.

Decomposition:
- Package ethernet_pkg: state_type enum, PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, BROADCAST_MAC 48'hFFFF_FFFF_FFFF, CRC32_POLY, CRC32_RESIDUE, MAC_BYTES=6, FCS_BYTES=4.
- Sub-module ethernet_crc32: byte-wide combinational-next/registered CRC with clear and enable. It is instantiated only under ETHERNET_FCS_CHECK_EN.

Test Plan:
- 7x0x55, 0xD5, 64-byte frame to slot 0 MAC with correct FCS -> 60 bytes on packet_data, valid=1'b1, packet_start on first byte, packet_end with packet_good=1.
- Same frame to broadcast with 4 slots, slots 1 and 3 enabled -> valid=4'b1010 for all 60 bytes.
- Third preamble byte 0x54 -> no output, dropped_frame_count 0->1, next good frame accepted.
- Unmatched destination MAC -> no output, count +1. A 40-byte runt to a matching MAC -> 36 bytes forwarded, packet_good=0.
- Correct frame with one payload bit flipped -> packet_good=0 with macro defined, 1 without.
- 1600-byte frame -> packet_end with packet_good=0 at byte 1519, count +1. Reset asserted mid-payload -> outputs 0 next cycle, no packet_end.
